// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial CLA arithmetic blocks.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int num_nib(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice; all carries are two-level sums of products.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g, p;
  logic       c1, c2, c3;

  assign g = x & y;
  assign p = x ^ y;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_sub_seq.sv
// Nibble-serial unsigned subtractor: diff = a + ~b + 1, one CLA slice reused per cycle.
module cla_sub_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int N  = num_nib(WIDTH);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < NIBBLE || (WIDTH % NIBBLE) != 0) begin : g_bad_width
    $error("cla_sub_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, res_nxt;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, bout_q, bout_d, zero_q, zero_d;
  logic [3:0]       nib_s;
  logic             nib_c;
  logic             last;

  cla4_slice u_slice (
    .x   (a_q[NIBBLE*int'(idx_q) +: NIBBLE]),
    .y   (b_q[NIBBLE*int'(idx_q) +: NIBBLE]),
    .cin (carry_q),
    .s   (nib_s),
    .cout(nib_c)
  );

  assign last = (idx_q == IW'(N-1));

  always_comb begin
    res_nxt = res_q;
    res_nxt[NIBBLE*int'(idx_q) +: NIBBLE] = nib_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = ~b;
        carry_d = 1'b1;
        idx_d   = '0;
        res_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d   = res_nxt;
        carry_d = nib_c;
        if (last) begin
          // Results commit on entry to DONE so they are already valid while done is high.
          diff_d  = res_nxt;
          bout_d  = ~nib_c;
          zero_d  = (res_nxt == '0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Scoreboard bench: directed 16-bit cases plus random ops on 4/8/32-bit instances.
module tb_cla_sub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- directed 16-bit instance ----------------
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0, diff;
  logic        busy, done, bout, zero;
  logic [17:0] q16[$];
  logic [15:0] last16 = '0;

  cla_sub_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
  );

  always @(posedge clk) begin : mon16
    logic [17:0] e;
    #1;
    if (rst) last16 = '0;
    else if (done) begin
      if (q16.size() == 0) chk("d16_unexp_done", 1, 0);
      else begin
        e = q16.pop_front();
        chk("d16_diff", diff, e[17:2]);
        chk("d16_bout", bout, e[1]);
        chk("d16_zero", zero, e[0]);
        last16 = e[17:2];
      end
    end else if (busy) chk("d16_hold", diff, last16);
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv);
    int c0, t, nb;
    a = ta; b = tbv; start = 1'b1;
    q16.push_back({16'(ta - tbv), ta < tbv, ta == tbv});
    c0 = cyc; nb = 0; t = 0;
    @(negedge clk); start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    forever begin
      if (busy) nb++;
      if (done || t > 20) break;
      @(negedge clk); t++;
    end
    if (done) chk("d16_latency", cyc - c0, 5);
    else      chk("d16_timeout", 0, 1);
    chk("d16_busy_cycles", nb, 5);
    @(negedge clk);
    chk("d16_idle_after", busy, 0);
  endtask

  // ---------------- random instances ----------------
  logic rrst = 1'b1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 8 : 32;
    localparam int N = W / 4;
    logic         rs = 1'b0, rbusy, rdone, rbo, rz, fin = 1'b0;
    logic [W-1:0] ra = '0, rb = '0, rd, last = '0;
    logic [W+1:0] q[$];

    cla_sub_seq #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rrst), .start(rs), .a(ra), .b(rb),
      .busy(rbusy), .done(rdone), .diff(rd), .bout(rbo), .zero(rz)
    );

    always @(posedge clk) begin : mon
      logic [W+1:0] e;
      #1;
      if (rrst) last = '0;
      else if (rdone) begin
        if (q.size() == 0) chk($sformatf("w%0d_unexp_done", W), 1, 0);
        else begin
          e = q.pop_front();
          chk($sformatf("w%0d_diff", W), rd, e[W+1:2]);
          chk($sformatf("w%0d_bout", W), rbo, e[1]);
          chk($sformatf("w%0d_zero", W), rz, e[0]);
          last = e[W+1:2];
        end
      end else if (rbusy) chk($sformatf("w%0d_hold", W), rd, last);
    end

    initial begin : drv
      logic [W-1:0] x, y;
      int c0, t;
      @(negedge clk);
      while (rrst) @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        x = W'($urandom);
        y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
        ra = x; rb = y; rs = 1'b1;
        q.push_back({W'(x - y), x < y, x == y});
        c0 = cyc; t = 0;
        // Junk start/operands while busy and in the done cycle must all be ignored.
        do begin
          @(negedge clk);
          rs = 1'($urandom_range(0, 1)); ra = W'($urandom); rb = W'($urandom);
          t++;
        end while (!rdone && t < N + 8);
        if (rdone) chk($sformatf("w%0d_latency", W), cyc - c0, N + 1);
        else       chk($sformatf("w%0d_timeout", W), 0, 1);
        @(negedge clk);
      end
      rs = 1'b0;
      fin = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int nd;
    rst = 1'b1; rrst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_zero", zero, 0);
    rst = 1'b0; rrst = 1'b0;

    run_op(16'h1234, 16'h0034);
    run_op(16'h0000, 16'h0001);
    run_op(16'h1000, 16'h0001);
    run_op(16'hFFFF, 16'hFFFF);

    // second start two cycles into an op is dropped
    a = 16'h0009; b = 16'h0002; start = 1'b1;
    q16.push_back({16'h0007, 1'b0, 1'b0});
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h0005; b = 16'h0003; start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("d16_single_done", nd, 1);
    run_op(16'h0005, 16'h0003);

    // reset on the second RUN cycle aborts; start with rst is ignored
    a = 16'h8000; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_zero", zero, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("abort_no_activity", nd, 0);
    run_op(16'h8000, 16'h0001);
    chk("d16_q_empty", q16.size(), 0);

    for (int t = 0; t < 40000; t++) begin
      if (g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin) break;
      @(negedge clk);
    end
    chk("rnd_finished", {g_rnd[2].fin, g_rnd[1].fin, g_rnd[0].fin}, 3'b111);
    @(negedge clk); @(negedge clk);
    chk("w4_q_empty",  g_rnd[0].q.size(), 0);
    chk("w8_q_empty",  g_rnd[1].q.size(), 0);
    chk("w32_q_empty", g_rnd[2].q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
